muldiv_sequencer: RTL
=====================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 Parameter: ITER, 32, iterations per non-special operation.
REQ-003 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-low.
REQ-005 Port: start  in  1  EX issues an M-extension op this cycle.
REQ-006 Port: funct3  in  3  op select (mul, mulh, mulhsu, mulhu, div, divu, rem, remu).
REQ-007 Port: op_a  in  32  forwarded rs1 value.
REQ-008 Port: op_b  in  32  forwarded rs2 value.
REQ-009 Port: flush  in  1  branch/jump squash of the in-flight op.
REQ-010 Port: stall  out  1  hold IF/ID/EX pipeline registers.
REQ-011 Port: done  out  1  result valid, one-cycle pulse.
REQ-012 Port: result  out  32  product/quotient/remainder.

Function
REQ-013 FSM states SHALL be IDLE, CALC, DONE.
REQ-014 Start acceptance: start sampled in IDLE or DONE (back-to-back), never in CALC.
  - Accepting latches funct3, op_a, op_b, and operand signs, and clears the counter.
  - Start in CALC is ignored.
REQ-015 Special cases go IDLE->DONE in one cycle; done is high the cycle after start.
  - div/divu with op_b==0: quotient 0xFFFFFFFF.
  - rem/remu with op_b==0: remainder = op_a.
  - div with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000.
  - rem with 0x80000000 / 0xFFFFFFFF: remainder 0.
REQ-016 Non-special ops: CALC runs exactly ITER cycles, then DONE; done is high 33 cycles after the start cycle.
REQ-017 Multiply: shift-add on operand magnitudes into a 64-bit accumulator, one bit per cycle.
  - Final negate when signs differ (mul, mulh: both signed; mulhsu: op_a only).
  - mul returns bits [31:0]; all others return [63:32].
REQ-018 Divide: restoring, one quotient bit per cycle, on magnitudes.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Signs apply only to div/rem.
REQ-019 Counter is 6 bits, increments once per CALC cycle, and exits CALC at ITER-1; no wrap beyond.
REQ-020 stall = (start & state!=CALC & ~flush) | (state==CALC), combinational.
  - stall is low in DONE, so the pipeline advances in the same cycle done is high.
REQ-021 done is high only in DONE.
  - result is registered and holds its value until the next DONE.
REQ-022 flush in CALC or DONE SHALL return the FSM to IDLE next cycle: no done pulse, result unchanged.
  - flush together with start: flush wins and the start is dropped.
REQ-023 Changes on op_a/op_b/funct3 after acceptance SHALL NOT affect the result.

Reset
REQ-024 With rst low, asynchronously: state=IDLE, counter=0, done=0, result=0, accumulators=0.
  - stall then follows REQ-020 with state=IDLE.
REQ-025 Reset mid-CALC SHALL abort silently.
  - The first start after rst rises SHALL be accepted normally.

Structure
REQ-026 muldiv_funct3_t enum (mul..remu, encodings 0-7) SHALL live in rv32i_types, beside the existing funct3 enums.
  - The FSM state enum stays local.
REQ-027 One sub-module, muldiv_datapath, SHALL hold the accumulator/shift registers, the magnitude conversion and the final sign fix.
  - The FSM and counter SHALL live in muldiv_sequencer.

Verification
REQ-028 mul 7 x 0xFFFFFFFD -> result 0xFFFFFFEB.
  - done at cycle 33; stall high cycles 0-32 and low at 33.
REQ-029 mulh 0x80000000 x 0x80000000 -> 0x40000000.
  - mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-030 div 7/0 -> 0xFFFFFFFF and rem 7/0 -> 7, both done at cycle 1.
  - div 0x80000000/0xFFFFFFFF -> 0x80000000, done at cycle 1.
REQ-031 rem 0xFFFFFFF9 % 2 -> 0xFFFFFFFF; divu 100/7 -> 14.
  - The second op is started in the DONE cycle of the first; its done is at +33.
REQ-032 flush at cycle 10 of a divide -> no done, state IDLE at cycle 11, result unchanged.
  - A new mul started at cycle 12 completes correctly.
REQ-033 rst low at cycle 5 of CALC -> immediate IDLE/done=0/result=0.
  - start after release: mulhsu 0xFFFFFFFF x 2 -> 0xFFFFFFFF.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I decode types: funct3 encodings for the base ISA groups and the
// M extension, imported by every stage that decodes an instruction.
package rv32i_types;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_funct3_t;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage <-> multiply/divide unit handshake: operands in, stall/done/result out.
interface muldiv_sequencer_if
    import rv32i_types::*;
#(
    parameter int XLEN = 32
);
    logic            start;
    muldiv_funct3_t  funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  stall, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output stall, done, result
    );
endinterface

// File: rtl/muldiv_datapath.sv
// Iterative multiply/divide datapath: operand magnitudes, a shared 64-bit
// shift-add / restoring-divide accumulator, and the final sign correction.
module muldiv_datapath
    import rv32i_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  muldiv_funct3_t  funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            special,
    output logic [XLEN-1:0] special_value,
    output logic [XLEN-1:0] final_value
);
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_funct3_t    op_q;
    logic [XLEN-1:0]   b_mag_q;
    logic [2*XLEN-1:0] acc_q;
    logic              neg_main_q;
    logic              neg_rem_q;

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;

    assign a_neg = (funct3 inside {MUL, MULH, MULHSU, DIV, REM}) & op_a[XLEN-1];
    assign b_neg = (funct3 inside {MUL, MULH, DIV, REM}) & op_b[XLEN-1];
    assign a_mag = a_neg ? -op_a : op_a;
    assign b_mag = b_neg ? -op_b : op_b;

    // Divide-by-zero and signed overflow bypass the iteration entirely.
    always_comb begin
        special       = 1'b0;
        special_value = '0;
        if (funct3[2]) begin
            if (op_b == '0) begin
                special       = 1'b1;
                special_value = (funct3 inside {DIV, DIVU}) ? ALL_ONES : op_a;
            end else if ((funct3 inside {DIV, REM}) && op_a == MOST_NEG && op_b == ALL_ONES) begin
                special       = 1'b1;
                special_value = (funct3 == DIV) ? MOST_NEG : '0;
            end
        end
    end

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN:0]   div_shift;
    logic [XLEN+1:0]   div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] acc_next;

    // Multiply keeps {partial_hi, multiplier} and shifts right; divide keeps
    // {remainder, dividend/quotient} and shifts left.
    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);
    assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    assign div_shift = {acc_q, 1'b0};
    assign div_diff  = {1'b0, div_shift[2*XLEN:XLEN]} - {2'b00, b_mag_q};
    assign div_next  = div_diff[XLEN+1] ? div_shift[2*XLEN-1:0]
                                        : {div_diff[XLEN-1:0], div_shift[XLEN-1:1], 1'b1};
    assign acc_next  = op_q[2] ? div_next : mul_next;

    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   quo_fixed, rem_fixed;

    assign prod_fixed = neg_main_q ? -acc_next : acc_next;
    assign quo_fixed  = neg_main_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    assign rem_fixed  = neg_rem_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];

    always_comb begin
        final_value = '0;
        case (op_q)
            MUL:                 final_value = prod_fixed[XLEN-1:0];
            MULH, MULHSU, MULHU: final_value = prod_fixed[2*XLEN-1:XLEN];
            DIV, DIVU:           final_value = quo_fixed;
            default:             final_value = rem_fixed;
        endcase
    end

    // NOTE: registers update with <= so every flop samples pre-edge values; mixing in = here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q       <= MUL;
            b_mag_q    <= '0;
            acc_q      <= '0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (load) begin
            op_q       <= funct3;
            b_mag_q    <= b_mag;
            acc_q      <= {{XLEN{1'b0}}, a_mag};
            neg_main_q <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
        end else if (step) begin
            acc_q      <= acc_next;
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// M-extension sequencer: accepts an op from EX, stalls the pipeline while the
// datapath iterates, and presents a registered result with a one-cycle done.
module muldiv_sequencer
    import rv32i_types::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input logic              clk,
    input logic              rst,
    muldiv_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [5:0] LAST = 6'(ITER - 1);

    state_t          state;
    logic [5:0]      cnt;
    logic            done_q;
    logic [XLEN-1:0] result_q;

    logic            in_calc;
    logic            accept;
    logic            special;
    logic [XLEN-1:0] special_value;
    logic [XLEN-1:0] final_value;

    assign in_calc = (state == CALC);
    // Flush squashes a same-cycle start, so it never reaches the datapath.
    assign accept  = bus.start & ~bus.flush & ~in_calc;

    assign bus.stall  = (bus.start & ~in_calc & ~bus.flush) | in_calc;
    assign bus.done   = done_q;
    assign bus.result = result_q;

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .clk           (clk),
        .rst           (rst),
        .load          (accept),
        .step          (in_calc),
        .funct3        (bus.funct3),
        .op_a          (bus.op_a),
        .op_b          (bus.op_b),
        .special       (special),
        .special_value (special_value),
        .final_value   (final_value)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                CALC: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else if (cnt == LAST) begin
                        state    <= DONE;
                        done_q   <= 1'b1;
                        result_q <= final_value;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                default: begin
                    if (accept) begin
                        cnt <= '0;
                        if (special) begin
                            state    <= DONE;
                            done_q   <= 1'b1;
                            result_q <= special_value;
                        end else begin
                            state <= CALC;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
